// File: rtl/alu_operand_stage.sv
// alu_operand_stage -- ID/EX register stage feeding the MIPS150 ALU.
//
// Resolves rs/rt through EX/MEM and MEM/WB forwarding, selects the ALU
// operands (rs or shamt for A; rt, sign/zero-extended imm for B), detects
// load-use hazards and registers the execute-stage bundle.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   stall, flush                 hold all outputs / load a bubble
//   id_*                         decoded instruction fields and RF read data
//   exm_*                        instruction one stage ahead (ALU result)
//   mwb_*                        write-back stage
//   hazard_stall                 combinational load-use stall to fetch/decode
//   A, B, ALUop, StoreData       registered execute operands
//   ex_valid, ex_wr_en,
//   ex_wr_addr, ex_is_load       registered destination info

// Single-operand forwarding mux. EX/MEM has priority over MEM/WB, a load in
// EX/MEM has no data yet, and $0 is never forwarded.
module alu_fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] addr,
  input  logic [DW-1:0] rf_val,
  input  logic          exm_wr_en,
  input  logic [RW-1:0] exm_wr_addr,
  input  logic [DW-1:0] exm_wr_data,
  input  logic          exm_is_load,
  input  logic          mwb_wr_en,
  input  logic [RW-1:0] mwb_wr_addr,
  input  logic [DW-1:0] mwb_wr_data,
  output logic [DW-1:0] fwd
);
  logic hit_exm, hit_mwb;

  assign hit_exm = exm_wr_en && (exm_wr_addr != '0) && (exm_wr_addr == addr) && !exm_is_load;
  assign hit_mwb = mwb_wr_en && (mwb_wr_addr != '0) && (mwb_wr_addr == addr);

  always_comb begin
    fwd = rf_val;
    if (hit_exm)      fwd = exm_wr_data;
    else if (hit_mwb) fwd = mwb_wr_data;
  end
endmodule

module alu_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [15:0]   id_imm,
  input  logic [4:0]    id_shamt,
  input  logic          id_a_sel,
  input  logic [1:0]    id_b_sel,
  input  logic [3:0]    id_alu_op,
  input  logic          id_wr_en,
  input  logic [RW-1:0] id_wr_addr,
  input  logic          id_is_load,
  input  logic          exm_wr_en,
  input  logic [RW-1:0] exm_wr_addr,
  input  logic [DW-1:0] exm_wr_data,
  input  logic          exm_is_load,
  input  logic          mwb_wr_en,
  input  logic [RW-1:0] mwb_wr_addr,
  input  logic [DW-1:0] mwb_wr_data,
  output logic          hazard_stall,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [3:0]    ALUop,
  output logic          ex_valid,
  output logic          ex_wr_en,
  output logic [RW-1:0] ex_wr_addr,
  output logic          ex_is_load,
  output logic [DW-1:0] StoreData
);
  localparam logic [3:0] ALU_XXX = 4'b1111;
  localparam int         NSRC    = 2;   // 0: rs, 1: rt

  typedef struct packed {
    logic          valid;
    logic          wr_en;
    logic [RW-1:0] wr_addr;
    logic          is_load;
    logic [3:0]    alu_op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] sd;
  } ex_t;

  localparam ex_t EX_BUBBLE = '{valid: 1'b0, wr_en: 1'b0, wr_addr: '0, is_load: 1'b0,
                                alu_op: ALU_XXX, a: '0, b: '0, sd: '0};

  logic [NSRC-1:0][RW-1:0] src_addr;
  logic [NSRC-1:0][DW-1:0] src_rf;
  logic [NSRC-1:0][DW-1:0] src_fwd;

  assign src_addr = {id_rt_addr, id_rs_addr};
  assign src_rf   = {id_rt_val,  id_rs_val};

  for (genvar g = 0; g < NSRC; g++) begin : g_fwd
    alu_fwd_mux #(.DW(DW), .RW(RW)) u_fwd (
      .addr        (src_addr[g]),
      .rf_val      (src_rf[g]),
      .exm_wr_en   (exm_wr_en),
      .exm_wr_addr (exm_wr_addr),
      .exm_wr_data (exm_wr_data),
      .exm_is_load (exm_is_load),
      .mwb_wr_en   (mwb_wr_en),
      .mwb_wr_addr (mwb_wr_addr),
      .mwb_wr_data (mwb_wr_data),
      .fwd         (src_fwd[g])
    );
  end

  // A load in EX/MEM has no data until MEM/WB, so a dependent instruction
  // must wait one cycle; MEM/WB forwarding covers it afterwards.
  logic ld_dst;
  assign ld_dst       = exm_is_load && exm_wr_en && (exm_wr_addr != '0);
  assign hazard_stall = id_valid && ld_dst &&
                        ((id_uses_rs && (exm_wr_addr == id_rs_addr)) ||
                         (id_uses_rt && (exm_wr_addr == id_rt_addr)));

  ex_t ex_nxt, ex_q;

  always_comb begin
    ex_nxt         = EX_BUBBLE;
    ex_nxt.valid   = id_valid;
    ex_nxt.wr_en   = id_wr_en && id_valid;
    ex_nxt.wr_addr = id_wr_addr;
    ex_nxt.is_load = id_is_load && id_valid;
    ex_nxt.alu_op  = id_alu_op;
    ex_nxt.a       = id_a_sel ? {{(DW-5){1'b0}}, id_shamt} : src_fwd[0];
    ex_nxt.sd      = src_fwd[1];
    unique case (id_b_sel)
      2'd1:    ex_nxt.b = {{(DW-16){id_imm[15]}}, id_imm};
      2'd2:    ex_nxt.b = {{(DW-16){1'b0}}, id_imm};
      default: ex_nxt.b = src_fwd[1];
    endcase
  end

  // stall outranks flush: a flush seen while stalled is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ex_q <= EX_BUBBLE;
    else if (stall)                  ex_q <= ex_q;
    else if (flush || hazard_stall)  ex_q <= EX_BUBBLE;
    else                             ex_q <= ex_nxt;
  end

  assign A          = ex_q.a;
  assign B          = ex_q.b;
  assign ALUop      = ex_q.alu_op;
  assign StoreData  = ex_q.sd;
  assign ex_valid   = ex_q.valid;
  assign ex_wr_en   = ex_q.wr_en;
  assign ex_wr_addr = ex_q.wr_addr;
  assign ex_is_load = ex_q.is_load;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed steps from the plan
// followed by a randomized run, all scored against a behavioural model.
module tb_alu_operand_stage;
  localparam logic [3:0] OP_ADDU = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_XXX  = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [31:0] id_rs_val, id_rt_val;
  logic [4:0]  id_rs_addr, id_rt_addr;
  logic        id_uses_rs, id_uses_rt;
  logic [15:0] id_imm;
  logic [4:0]  id_shamt;
  logic        id_a_sel;
  logic [1:0]  id_b_sel;
  logic [3:0]  id_alu_op;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic        id_is_load;
  logic        exm_wr_en;
  logic [4:0]  exm_wr_addr;
  logic [31:0] exm_wr_data;
  logic        exm_is_load;
  logic        mwb_wr_en;
  logic [4:0]  mwb_wr_addr;
  logic [31:0] mwb_wr_data;
  logic        hazard_stall;
  logic [31:0] A, B, StoreData;
  logic [3:0]  ALUop;
  logic        ex_valid, ex_wr_en, ex_is_load;
  logic [4:0]  ex_wr_addr;

  int errors = 0;
  int checks = 0;

  // expected registered state
  logic [31:0] e_a, e_b, e_sd;
  logic [3:0]  e_op;
  logic        e_valid, e_wr_en, e_is_load;
  logic [4:0]  e_wr_addr;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_alu_op(id_alu_op), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .exm_wr_en(exm_wr_en), .exm_wr_addr(exm_wr_addr),
    .exm_wr_data(exm_wr_data), .exm_is_load(exm_is_load), .mwb_wr_en(mwb_wr_en),
    .mwb_wr_addr(mwb_wr_addr), .mwb_wr_data(mwb_wr_data), .hazard_stall(hazard_stall),
    .A(A), .B(B), .ALUop(ALUop), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en),
    .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load), .StoreData(StoreData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Value a source register really holds at decode time: the newest
  // in-flight producer that already has its result, else the RF copy.
  function automatic logic [31:0] m_src(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (exm_wr_en && !exm_is_load && exm_wr_addr == r) return exm_wr_data;
    if (mwb_wr_en && mwb_wr_addr == r) return mwb_wr_data;
    return rf;
  endfunction

  function automatic logic m_hazard();
    logic needs;
    if (!(id_valid && exm_is_load && exm_wr_en) || exm_wr_addr == 0) return 1'b0;
    needs = (id_uses_rs && id_rs_addr == exm_wr_addr) || (id_uses_rt && id_rt_addr == exm_wr_addr);
    return needs;
  endfunction

  task automatic m_bubble();
    e_valid = 0; e_wr_en = 0; e_is_load = 0; e_op = OP_XXX;
    e_a = 0; e_b = 0; e_sd = 0; e_wr_addr = 0;
  endtask

  task automatic m_edge();
    logic [31:0] rt;
    if (stall) return;
    if (flush || m_hazard()) begin m_bubble(); return; end
    rt        = m_src(id_rt_addr, id_rt_val);
    e_valid   = id_valid;
    e_wr_en   = id_wr_en & id_valid;
    e_is_load = id_is_load & id_valid;
    e_wr_addr = id_wr_addr;
    e_op      = id_alu_op;
    e_a       = id_a_sel ? 32'(id_shamt) : m_src(id_rs_addr, id_rs_val);
    e_sd      = rt;
    case (id_b_sel)
      2'd1:    e_b = 32'(signed'(id_imm));
      2'd2:    e_b = 32'(id_imm);
      default: e_b = rt;
    endcase
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".A"}, A, e_a);
    chk({tag, ".B"}, B, e_b);
    chk({tag, ".sd"}, StoreData, e_sd);
    chk({tag, ".op"}, 32'(ALUop), 32'(e_op));
    chk({tag, ".vld"}, 32'(ex_valid), 32'(e_valid));
    chk({tag, ".wen"}, 32'(ex_wr_en), 32'(e_wr_en));
    chk({tag, ".ld"}, 32'(ex_is_load), 32'(e_is_load));
    if (e_valid) chk({tag, ".wa"}, 32'(ex_wr_addr), 32'(e_wr_addr));
  endtask

  // inputs are already driven; check the hazard, clock once, check state
  task automatic step(input string tag);
    #1;
    chk({tag, ".hz"}, 32'(hazard_stall), 32'(m_hazard()));
    m_edge();
    @(posedge clk); #1;
    cmp_all(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_val = 0; id_rt_val = 0; id_rs_addr = 0; id_rt_addr = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_imm = 0; id_shamt = 0;
    id_a_sel = 0; id_b_sel = 0; id_alu_op = OP_ADDU;
    id_wr_en = 0; id_wr_addr = 0; id_is_load = 0;
    exm_wr_en = 0; exm_wr_addr = 0; exm_wr_data = 0; exm_is_load = 0;
    mwb_wr_en = 0; mwb_wr_addr = 0; mwb_wr_data = 0;
  endtask

  task automatic addu(input logic [4:0] rs, input logic [31:0] rsv,
                      input logic [4:0] rt, input logic [31:0] rtv, input logic [4:0] rd);
    id_valid = 1; id_rs_addr = rs; id_rs_val = rsv; id_rt_addr = rt; id_rt_val = rtv;
    id_uses_rs = 1; id_uses_rt = 1; id_a_sel = 0; id_b_sel = 0; id_alu_op = OP_ADDU;
    id_wr_en = 1; id_wr_addr = rd; id_is_load = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    m_bubble();
    // reset held while inputs toggle
    for (int i = 0; i < 3; i++) begin
      addu(5'(i + 1), $urandom, 5'(i + 2), $urandom, 5'd9);
      @(posedge clk); #1;
    end
    chk("rst.A", A, 32'h0);
    chk("rst.B", B, 32'h0);
    chk("rst.vld", 32'(ex_valid), 32'h0);
    chk("rst.op", 32'(ALUop), 32'(OP_XXX));
    rst_n = 1;

    addu(5'd1, 32'd5, 5'd2, 32'd7, 5'd4);
    step("first");
    chk("first.A5", A, 32'd5);
    chk("first.B7", B, 32'd7);
    chk("first.vld1", 32'(ex_valid), 32'd1);

    // forwarding priority
    addu(5'd3, 32'h99, 5'd0, 32'h0, 5'd5);
    exm_wr_en = 1; exm_wr_addr = 3; exm_wr_data = 32'h11;
    mwb_wr_en = 1; mwb_wr_addr = 3; mwb_wr_data = 32'h22;
    step("fwd_exm");
    chk("fwd_exm.k", A, 32'h11);
    exm_wr_en = 0;
    step("fwd_mwb");
    chk("fwd_mwb.k", A, 32'h22);
    exm_wr_en = 1; id_rs_addr = 0; exm_wr_addr = 0; mwb_wr_addr = 0;
    step("fwd_r0");
    chk("fwd_r0.k", A, 32'h99);
    exm_wr_en = 0; mwb_wr_en = 0;

    // immediates and shamt
    addu(5'd1, 32'h1, 5'd2, 32'h1234, 5'd6);
    id_imm = 16'h8001; id_b_sel = 1;
    step("sext");
    chk("sext.k", B, 32'hFFFF8001);
    chk("sext.sd", StoreData, 32'h1234);
    id_b_sel = 2;
    step("zext");
    chk("zext.k", B, 32'h00008001);
    id_b_sel = 0; id_a_sel = 1; id_shamt = 5'd4; id_alu_op = OP_SLL; id_uses_rs = 0;
    mwb_wr_en = 1; mwb_wr_addr = 2; mwb_wr_data = 32'h5A5A;
    step("sll");
    chk("sll.A", A, 32'd4);
    chk("sll.B", B, 32'h5A5A);
    mwb_wr_en = 0; id_a_sel = 0;

    // load-use: one bubble, then MEM/WB supplies the data
    addu(5'd1, 32'h3, 5'd8, 32'hDEAD, 5'd10);
    exm_wr_en = 1; exm_wr_addr = 8; exm_is_load = 1; exm_wr_data = 32'hBAD;
    #1;
    chk("lu.hz1", 32'(hazard_stall), 32'd1);
    step("lu_bub");
    chk("lu_bub.vld0", 32'(ex_valid), 32'd0);
    exm_wr_en = 0; exm_is_load = 0;
    mwb_wr_en = 1; mwb_wr_addr = 8; mwb_wr_data = 32'hCAFE;
    step("lu_cap");
    chk("lu_cap.B", B, 32'hCAFE);
    chk("lu_cap.sd", StoreData, 32'hCAFE);
    mwb_wr_en = 0;

    // stall outranks flush
    addu(5'd1, 32'h77, 5'd2, 32'h88, 5'd11);
    stall = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin
      id_rs_val = $urandom; id_rt_val = $urandom;
      step("stall");
    end
    chk("stall.A", A, 32'hCAFE + 0 == 0 ? 0 : A === A ? e_a : 0);
    stall = 0;
    step("flush");
    chk("flush.vld0", 32'(ex_valid), 32'd0);
    chk("flush.op", 32'(ALUop), 32'(OP_XXX));
    flush = 0;
    step("resume");
    chk("resume.vld1", 32'(ex_valid), 32'd1);

    // async reset between edges
    @(negedge clk);
    rst_n = 0;
    #1;
    m_bubble();
    chk("areset.vld", 32'(ex_valid), 32'd0);
    chk("areset.A", A, 32'd0);
    cmp_all("areset");
    #2 rst_n = 1;

    // randomized run
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      id_valid    = ($urandom_range(0, 4) != 0);
      id_rs_val   = $urandom; id_rt_val = $urandom;
      id_rs_addr  = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom); id_uses_rt = 1'($urandom);
      id_imm      = 16'($urandom); id_shamt = 5'($urandom);
      id_a_sel    = 1'($urandom); id_b_sel = 2'($urandom);
      id_alu_op   = 4'($urandom); id_wr_en = 1'($urandom);
      id_wr_addr  = 5'($urandom); id_is_load = 1'($urandom);
      exm_wr_en   = 1'($urandom); exm_wr_addr = 5'($urandom_range(0, 3));
      exm_wr_data = $urandom;     exm_is_load = ($urandom_range(0, 3) == 0);
      mwb_wr_en   = 1'($urandom); mwb_wr_addr = 5'($urandom_range(0, 3));
      mwb_wr_data = $urandom;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the MIPS150 ALU.
- Selects the ALU operands from register-file values, the immediate or the shift amount, and applies EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and registers A, B, ALUop, destination and store data for the execute stage.
- Handles stall, flush and bubble insertion.

Parameters:
- DW, 32, datapath width (A, B, forwarded data); only 32 is supported.
- RW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  downstream hold: all output registers keep their value.
- flush  in  1  kill the instruction being captured; load a bubble.
- id_valid  in  1  decode holds a real instruction.
- id_rs_val, id_rt_val  in  32  register-file read data.
- id_rs_addr, id_rt_addr  in  5  source register numbers.
- id_uses_rs, id_uses_rt  in  1  instruction actually reads rs / rt (for the hazard check).
- id_imm  in  16  instruction immediate.
- id_shamt  in  5  instruction shamt field.
- id_a_sel  in  1  0: A=rs; 1: A={27'b0,shamt}.
- id_b_sel  in  2  0: B=rt; 1: B=sign-extended imm; 2: B=zero-extended imm; 3: B=rt.
- id_alu_op  in  4  ALUop encoding from ALUop.vh.
- id_wr_en, id_wr_addr  in  1/5  destination write-back info.
- id_is_load  in  1  instruction is a load.
- exm_wr_en, exm_wr_addr, exm_wr_data, exm_is_load  in  1/5/32/1  instruction one stage ahead (its ALU Out).
- mwb_wr_en, mwb_wr_addr, mwb_wr_data  in  1/5/32  write-back stage.
- hazard_stall  out  1  combinational; decode and fetch must hold.
- A, B  out  32  registered ALU operands.
- ALUop  out  4  registered ALU operation.
- ex_valid  out  1  registered valid.
- ex_wr_en, ex_wr_addr, ex_is_load  out  1/5/1  registered destination info.
- StoreData  out  32  registered forwarded rt value (for stores).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - A, B, StoreData = 0.
  - ALUop = `ALU_XXX.
  - ex_valid, ex_wr_en, ex_is_load = 0; ex_wr_addr = 0.
  - Reset mid-operation discards the in-flight instruction immediately; the first capture happens on the first rising edge after release.
- Forwarding, per source operand (rs, rt), combinational:
  - If exm_wr_en & exm_wr_addr!=0 & exm_wr_addr==addr & !exm_is_load, use exm_wr_data.
  - Else if mwb_wr_en & mwb_wr_addr!=0 & mwb_wr_addr==addr, use mwb_wr_data.
  - Else use the register-file value.
  - EX/MEM wins when both match. Register $0 is never forwarded.
- Operand select:
  - A = fwd_rs, or {27'b0, id_shamt} when a_sel=1.
  - B per b_sel. Sign extension is {{16{imm[15]}}, imm}; zero extension is {16'b0, imm}.
  - StoreData = fwd_rt regardless of b_sel.
- hazard_stall = id_valid & exm_is_load & exm_wr_en & exm_wr_addr!=0 & ((id_uses_rs & exm_wr_addr==id_rs_addr) | (id_uses_rt & exm_wr_addr==id_rt_addr)). No dependence on stall or flush.
- Register update priority per rising edge:
  1. stall=1: hold every output, even when flush=1 (flush is ignored while stalled; upstream must reassert it).
  2. flush=1: bubble — ex_valid=0, ex_wr_en=0, ex_is_load=0, ALUop=`ALU_XXX, A=B=StoreData=0.
  3. hazard_stall=1: bubble as in flush.
  4. Otherwise capture the selected values. ex_valid=id_valid. ex_wr_en=id_wr_en&id_valid. ex_is_load=id_is_load&id_valid.
- A bubble never writes back. ex_wr_addr may carry any value in a bubble; the bench checks it only when ex_valid=1.
- Latency: 1 cycle from decode inputs to the registered outputs. Throughput is 1 instruction per cycle absent hazards.
- A load-use dependence costs exactly one bubble. On the next cycle the load sits in MEM/WB and the MEM/WB path forwards its data.

Test Plan:
- Reset: hold rst_n=0 with inputs toggling. Required: A=B=0, ex_valid=0, ALUop=`ALU_XXX. Then release rst_n, apply ADDU with rs_val=5, rt_val=7, b_sel=0. Required next edge: A=5, B=7, ex_valid=1.
- Forward priority: id_rs_addr=3 with exm wr $3=0x11 and mwb wr $3=0x22 → A=0x11. Same again with exm_wr_en=0 → A=0x22. Same with id_rs_addr=0 → A=id_rs_val.
- Operand select:
  - imm=0x8001 with b_sel=1 → B=0xFFFF8001; b_sel=2 → B=0x00008001.
  - SLL with a_sel=1, shamt=4 → A=4, B=fwd_rt.
- Load-use: exm_is_load=1, exm_wr_addr=8, id_rt_addr=8, id_uses_rt=1. Required: hazard_stall=1 and a bubble next edge (ex_valid=0). Next cycle, with the load on mwb (data 0xCAFE), capture gives B=0xCAFE and StoreData=0xCAFE.
- Stall vs flush:
  - stall=1 with flush=1 for 3 cycles → outputs unchanged.
  - stall=0, flush=1 → bubble.
  - Both low → normal capture.
- Async reset mid-stream: drop rst_n between edges with ex_valid=1. Required: outputs clear immediately, before the next clock edge.
